// File: rtl/instr_pack_pkg.sv
// instr_pack_pkg: shared state encoding, error-bit indices and helpers for the instruction packer
package instr_pack_pkg;

    typedef logic [0:0] state_t;
    localparam state_t ACCUM = 1'b0;
    localparam state_t FLUSH = 1'b1;

    localparam int ERR_PARTIAL    = 0;
    localparam int ERR_EMPTY_LAST = 1;

    function automatic int lanes_of(input int width, input int lane_width);
        return width / lane_width;
    endfunction

    function automatic int lane_cnt_width(input int m_width, input int lane_width);
        return $clog2(m_width / lane_width) + 1;
    endfunction

    function automatic bit params_ok(input int s_w, input int m_w, input int lane_w, input int depth);
        return (lane_w > 0) && (lane_w % 8 == 0) && (s_w % lane_w == 0) && (m_w % lane_w == 0) &&
               (m_w >= s_w) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/instr_sync_fifo.sv
// instr_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module instr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic [WIDTH-1:0]       rd_data,
    input  logic                   rd_en,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push, pop;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/instr_word_packer.sv
// instr_word_packer: compacts full 32-bit lanes of an input stream into wide instruction words
module instr_word_packer
    import instr_pack_pkg::*;
#(
    parameter int S_DATA_WIDTH  = 64,
    parameter int M_DATA_WIDTH  = 256,
    parameter int LANE_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int FLUSH_ON_LAST = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [S_DATA_WIDTH-1:0]                     s_axis_tdata,
    input  logic [S_DATA_WIDTH/8-1:0]                   s_axis_tkeep,
    input  logic                                        s_axis_tvalid,
    input  logic                                        s_axis_tlast,
    output logic                                        s_axis_tready,
    output logic [M_DATA_WIDTH-1:0]                     m_axis_tdata,
    output logic                                        m_axis_tvalid,
    output logic                                        m_axis_tlast,
    input  logic                                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]                 fifo_level,
    output logic [$clog2(M_DATA_WIDTH/LANE_WIDTH):0]    lane_count,
    output logic [1:0]                                  err
);
    localparam int NS    = lanes_of(S_DATA_WIDTH, LANE_WIDTH);
    localparam int NM    = lanes_of(M_DATA_WIDTH, LANE_WIDTH);
    localparam int BPL   = LANE_WIDTH / 8;
    localparam int ACC_W = (NM + NS - 1) * LANE_WIDTH;
    localparam int LCW   = lane_cnt_width(M_DATA_WIDTH, LANE_WIDTH);

    if (!params_ok(S_DATA_WIDTH, M_DATA_WIDTH, LANE_WIDTH, FIFO_DEPTH)) begin : g_bad_params
        $error("instr_word_packer: illegal parameter combination");
    end

    logic [ACC_W-1:0]        acc, acc_nxt, shifted_in, merged, rem;
    logic [S_DATA_WIDTH-1:0] beat;
    logic [M_DATA_WIDTH-1:0] top_word, push_data, head_data;
    logic [LCW-1:0]          cnt_nxt;
    logic [1:0]              err_nxt;
    state_t                  state, state_nxt;
    logic                    ready_en, last_flag, flag_nxt, partial, accept;
    logic                    push, push_last, fifo_full, fifo_empty, head_last;
    int                      k, total;

    assign accept        = s_axis_tvalid && s_axis_tready;
    assign s_axis_tready = ready_en && state == ACCUM && !fifo_full;
    assign shifted_in    = (ACC_W'(beat) << (ACC_W - S_DATA_WIDTH)) >> (int'(lane_count) * LANE_WIDTH);
    assign merged        = acc | shifted_in;
    assign rem           = merged << M_DATA_WIDTH;
    assign top_word      = merged[ACC_W-1 -: M_DATA_WIDTH];
    assign total         = int'(lane_count) + k;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = head_last && m_axis_tvalid;
    assign m_axis_tdata  = head_data;

    // compact the fully-kept lanes of the beat MSB-first, higher lane index first
    always_comb begin
        beat    = '0;
        k       = 0;
        partial = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (&s_axis_tkeep[i*BPL +: BPL]) begin
                beat[(NS-1-k)*LANE_WIDTH +: LANE_WIDTH] = s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH];
                k = k + 1;
            end else if (|s_axis_tkeep[i*BPL +: BPL]) begin
                partial = 1'b1;
            end
        end
    end

    // accumulate lanes, emit full or padded words, and track packet-end handling
    always_comb begin
        push      = 1'b0;
        push_data = top_word;
        push_last = 1'b0;
        acc_nxt   = acc;
        cnt_nxt   = lane_count;
        state_nxt = state;
        flag_nxt  = last_flag;
        err_nxt   = err;
        if (state == FLUSH) begin
            if (!fifo_full) begin
                push      = 1'b1;
                push_data = acc[ACC_W-1 -: M_DATA_WIDTH];
                push_last = 1'b1;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = ACCUM;
            end
        end else if (accept) begin
            err_nxt[ERR_PARTIAL] = err[ERR_PARTIAL] | partial;
            if (s_axis_tlast && total == 0) err_nxt[ERR_EMPTY_LAST] = 1'b1;
            if (FLUSH_ON_LAST != 0 && s_axis_tlast && total != 0) begin
                push      = 1'b1;
                push_last = total <= NM;
                acc_nxt   = total > NM ? rem : '0;
                cnt_nxt   = total > NM ? LCW'(total - NM) : '0;
                state_nxt = total > NM ? FLUSH : ACCUM;
            end else if (total >= NM) begin
                push      = 1'b1;
                push_last = FLUSH_ON_LAST == 0 && (last_flag || s_axis_tlast);
                acc_nxt   = rem;
                cnt_nxt   = LCW'(total - NM);
                flag_nxt  = 1'b0;
            end else begin
                acc_nxt   = merged;
                cnt_nxt   = LCW'(total);
                flag_nxt  = FLUSH_ON_LAST == 0 && (last_flag || s_axis_tlast);
            end
        end
    end

    // register packer state; ready is held off for the reset cycle itself
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            lane_count <= '0;
            state      <= ACCUM;
            ready_en   <= 1'b0;
            last_flag  <= 1'b0;
            err        <= '0;
        end else begin
            acc        <= acc_nxt;
            lane_count <= cnt_nxt;
            state      <= state_nxt;
            ready_en   <= 1'b1;
            last_flag  <= flag_nxt;
            err        <= err_nxt;
        end
    end

    instr_sync_fifo #(
        .WIDTH(M_DATA_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_data({push_last, push_data}),
        .wr_en  (push),
        .full   (fifo_full),
        .rd_data({head_last, head_data}),
        .rd_en  (m_axis_tready),
        .empty  (fifo_empty),
        .count  (fifo_level)
    );

endmodule

// File: tb/tb_instr_word_packer.sv
// tb_instr_word_packer: directed self-checking bench for the instruction word packer
module tb_instr_word_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  s_axis_tdata = '0;
    logic [7:0]   s_axis_tkeep = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;
    logic [4:0]   fifo_level;
    logic [3:0]   lane_count;
    logic [1:0]   err;

    int total_checks = 0;
    int bad = 0;
    logic [256:0] q[$];
    logic [256:0] h;

    always #5 clk = ~clk;

    instr_word_packer dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .fifo_level(fifo_level), .lane_count(lane_count), .err(err)
    );

    always @(posedge clk) if (m_axis_tvalid && m_axis_tready) q.push_back({m_axis_tlast, m_axis_tdata});

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lv(input logic [7:0] tag, input int n);
        return {tag, 24'(n)};
    endfunction

    function automatic logic [63:0] b2(input logic [7:0] tag, input int n);
        return {lv(tag, n), lv(tag, n + 1)};
    endfunction

    function automatic logic [255:0] mkword(input logic [7:0] tag, input int first, input int n);
        logic [255:0] w = '0;
        for (int j = 0; j < n; j++) w[255-32*j -: 32] = lv(tag, first + j);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        q.delete();
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] kp, input logic lst);
        int n = 0;
        s_axis_tdata = d;
        s_axis_tkeep = kp;
        s_axis_tlast = lst;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 200) begin
            tick();
            n++;
        end
        if (!s_axis_tready) begin
            total_checks++;
            bad++;
            $display("FAIL send_timeout: s_axis_tready=%b required 1", s_axis_tready);
        end
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_checks++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready: got %b expected 0", s_axis_tready); end
        total_checks++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
        total_checks++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b expected 0", m_axis_tlast); end
        total_checks++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL rst_lane_count: got %0d expected 0", lane_count); end
        total_checks++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err: got %b expected 00", err); end
        reset = 1'b0;
        total_checks++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_release_tready: got %b expected 0", s_axis_tready); end
        tick();
        total_checks++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_full_word();
        q.delete();
        send(b2(8'hA0, 0), 8'hFF, 1'b0);
        send(b2(8'hA0, 2), 8'hFF, 1'b0);
        total_checks++; if (lane_count !== 4'd4) begin bad++; $display("FAIL A_mid_lanes: got %0d expected 4", lane_count); end
        send(b2(8'hA0, 4), 8'hFF, 1'b0);
        send(b2(8'hA0, 6), 8'hFF, 1'b0);
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL A_lane_count: got %0d expected 0", lane_count); end
        total_checks++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL A_level: got %0d expected 1", fifo_level); end
        tick();
        tick();
        h = q.size() > 0 ? q[0] : 'x;
        total_checks++; if (q.size() != 1) begin bad++; $display("FAIL A_count: got %0d expected 1", q.size()); end
        total_checks++; if (h !== {1'b0, mkword(8'hA0, 0, 8)}) begin bad++; $display("FAIL A_word: got %h expected %h", h, {1'b0, mkword(8'hA0, 0, 8)}); end
    endtask

    task automatic test_single_lane();
        q.delete();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send({32'hDEADBEEF, lv(8'hB0, i)}, 8'h0F, 1'b0);
            else send({lv(8'hB0, i), 32'hDEADBEEF}, 8'hF0, 1'b0);
        end
        total_checks++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL B_level: got %0d expected 1", fifo_level); end
        total_checks++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL B_tvalid: got %b expected 1", m_axis_tvalid); end
        total_checks++; if (m_axis_tdata !== mkword(8'hB0, 0, 8)) begin bad++; $display("FAIL B_head: got %h expected %h", m_axis_tdata, mkword(8'hB0, 0, 8)); end
        m_axis_tready = 1'b1;
        tick();
        tick();
        total_checks++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL B_drained: got %0d expected 0", fifo_level); end
        total_checks++; if (q.size() != 1) begin bad++; $display("FAIL B_count: got %0d expected 1", q.size()); end
        total_checks++; if (err !== 2'b00) begin bad++; $display("FAIL B_err: got %b expected 00", err); end
    endtask

    task automatic test_carry();
        q.delete();
        send({32'hDEADBEEF, lv(8'hC0, 0)}, 8'h0F, 1'b0);
        send(b2(8'hC0, 1), 8'hFF, 1'b0);
        send(b2(8'hC0, 3), 8'hFF, 1'b0);
        send(b2(8'hC0, 5), 8'hFF, 1'b0);
        total_checks++; if (lane_count !== 4'd7) begin bad++; $display("FAIL C_lanes7: got %0d expected 7", lane_count); end
        total_checks++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL C_level0: got %0d expected 0", fifo_level); end
        send(b2(8'hC0, 7), 8'hFF, 1'b0);
        total_checks++; if (lane_count !== 4'd1) begin bad++; $display("FAIL C_lanes1: got %0d expected 1", lane_count); end
        total_checks++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL C_level1: got %0d expected 1", fifo_level); end
        tick();
        tick();
        h = q.size() > 0 ? q[0] : 'x;
        total_checks++; if (h !== {1'b0, mkword(8'hC0, 0, 8)}) begin bad++; $display("FAIL C_word: got %h expected %h", h, {1'b0, mkword(8'hC0, 0, 8)}); end
        do_reset();
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL C_reset_lanes: got %0d expected 0", lane_count); end
    endtask

    task automatic test_flush_partial();
        q.delete();
        send(b2(8'hD0, 0), 8'hFF, 1'b0);
        send({32'hDEADBEEF, lv(8'hD0, 2)}, 8'h0F, 1'b0);
        send(b2(8'hD0, 3), 8'hFF, 1'b1);
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL D_lanes: got %0d expected 0", lane_count); end
        total_checks++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL D_tready: got %b expected 1", s_axis_tready); end
        send(b2(8'hD0, 5), 8'hFF, 1'b1);
        tick();
        tick();
        h = q.size() > 0 ? q[0] : 'x;
        total_checks++; if (h !== {1'b1, mkword(8'hD0, 0, 5)}) begin bad++; $display("FAIL D_word0: got %h expected %h", h, {1'b1, mkword(8'hD0, 0, 5)}); end
        h = q.size() > 1 ? q[1] : 'x;
        total_checks++; if (h !== {1'b1, mkword(8'hD0, 5, 2)}) begin bad++; $display("FAIL D_word1: got %h expected %h", h, {1'b1, mkword(8'hD0, 5, 2)}); end
    endtask

    task automatic test_flush_split();
        q.delete();
        send(b2(8'hE0, 0), 8'hFF, 1'b0);
        send(b2(8'hE0, 2), 8'hFF, 1'b0);
        send(b2(8'hE0, 4), 8'hFF, 1'b0);
        send({32'hDEADBEEF, lv(8'hE0, 6)}, 8'h0F, 1'b0);
        send(b2(8'hE0, 7), 8'hFF, 1'b1);
        total_checks++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL E_flush_tready: got %b expected 0", s_axis_tready); end
        total_checks++; if (lane_count !== 4'd1) begin bad++; $display("FAIL E_flush_lanes: got %0d expected 1", lane_count); end
        tick();
        total_checks++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL E_ready_back: got %b expected 1", s_axis_tready); end
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL E_lanes_clear: got %0d expected 0", lane_count); end
        tick();
        tick();
        h = q.size() > 0 ? q[0] : 'x;
        total_checks++; if (h !== {1'b0, mkword(8'hE0, 0, 8)}) begin bad++; $display("FAIL E_word0: got %h expected %h", h, {1'b0, mkword(8'hE0, 0, 8)}); end
        h = q.size() > 1 ? q[1] : 'x;
        total_checks++; if (h !== {1'b1, mkword(8'hE0, 8, 1)}) begin bad++; $display("FAIL E_word1: got %h expected %h", h, {1'b1, mkword(8'hE0, 8, 1)}); end
    endtask

    task automatic test_errors();
        do_reset();
        send(64'h1111_2222_3333_4444, 8'h00, 1'b0);
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL ERR_empty_lanes: got %0d expected 0", lane_count); end
        total_checks++; if (err !== 2'b00) begin bad++; $display("FAIL ERR_empty_beat: got %b expected 00", err); end
        send(64'h1111_2222_3333_4444, 8'h00, 1'b1);
        total_checks++; if (err !== 2'b10) begin bad++; $display("FAIL ERR_empty_last: got %b expected 10", err); end
        total_checks++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL ERR_no_push: got %0d expected 0", fifo_level); end
        send({32'h5555_6666, lv(8'hF0, 0)}, 8'h3F, 1'b0);
        total_checks++; if (err !== 2'b11) begin bad++; $display("FAIL ERR_partial: got %b expected 11", err); end
        total_checks++; if (lane_count !== 4'd1) begin bad++; $display("FAIL ERR_partial_lanes: got %0d expected 1", lane_count); end
        tick();
        total_checks++; if (q.size() != 0) begin bad++; $display("FAIL ERR_words: got %0d expected 0", q.size()); end
        do_reset();
        total_checks++; if (err !== 2'b00) begin bad++; $display("FAIL ERR_cleared: got %b expected 00", err); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 64; i++) send(b2(8'h60, 2 * i), 8'hFF, 1'b0);
        total_checks++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL BP_level: got %0d expected 16", fifo_level); end
        total_checks++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL BP_tready: got %b expected 0", s_axis_tready); end
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL BP_lanes: got %0d expected 0", lane_count); end
        m_axis_tready = 1'b1;
        while (q.size() < 16 && n < 100) begin
            tick();
            n++;
        end
        total_checks++; if (q.size() != 16) begin bad++; $display("FAIL BP_count: got %0d expected 16", q.size()); end
        for (int w = 0; w < 16; w++) begin
            h = q.size() > w ? q[w] : 'x;
            total_checks++;
            if (h !== {1'b0, mkword(8'h60, 8 * w, 8)}) begin
                bad++;
                $display("FAIL BP_word%0d: got %h expected %h", w, h, {1'b0, mkword(8'h60, 8 * w, 8)});
            end
        end
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(b2(8'h70, 2 * i), 8'hFF, 1'b0);
        total_checks++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL MR_level: got %0d expected 1", fifo_level); end
        total_checks++; if (lane_count !== 4'd2) begin bad++; $display("FAIL MR_lanes: got %0d expected 2", lane_count); end
        reset = 1'b1;
        tick();
        total_checks++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL MR_reset_level: got %0d expected 0", fifo_level); end
        total_checks++; if (lane_count !== 4'd0) begin bad++; $display("FAIL MR_reset_lanes: got %0d expected 0", lane_count); end
        total_checks++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL MR_reset_tvalid: got %b expected 0", m_axis_tvalid); end
        reset = 1'b0;
        m_axis_tready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_single_lane();
        test_carry();
        test_flush_partial();
        test_flush_split();
        test_errors();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total_checks, bad);
        $finish;
    end

endmodule
